mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Shares one registered W-bit output channel between N requesters.
- Each requester has a valid/ready handshake. A round-robin arbiter picks one requester per beat and steers its data through an N:1 mux into a single output register.
- Sits between independent producers and one consumer; it is the scheduling controller for the shared mux datapath.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 8, data width in bits.
- MAX_BURST, 4, maximum consecutive beats per grant. Used only when ARB_BURST_EN is defined; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  N  per-requester valid; bit i belongs to requester i.
- in_data  input  N*W  flattened data; requester i occupies bits [i*W +: W].
- in_ready  output  N  per-requester ready; at most one bit high in any cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  output beat data.
- out_ready  input  1  consumer accepts the beat.
- out_src  output  clog2(N)  index of the requester whose beat is in the output register.

Behaviour:
- Reset, synchronous, active-high:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=N-1, so requester 0 has highest priority first.
  - Burst counter = 0.
- can_load = !out_valid | out_ready (combinational).
- Arbitration (combinational):
  - Search order is ptr+1, ptr+2, ... wrapping modulo N.
  - The winner is the first i with in_valid[i]=1.
  - in_ready[winner] = can_load; all other in_ready bits = 0.
  - No valid requester, or can_load=0: in_ready is all zero.
- Transfer: in_valid[i] & in_ready[i] at edge k gives, after edge k:
  - out_data = in_data[i], out_src = i, out_valid = 1, ptr = i.
  - Latency from input handshake to out_valid is 1 cycle.
- Drain: out_valid & out_ready with no new transfer in the same cycle gives out_valid=0 next cycle. out_data and out_src hold their last values.
- Simultaneous drain and load: both happen in the same cycle. out_valid stays 1 and the new beat replaces the old, so full throughput is one beat per cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_src and ptr are frozen and in_ready is all zero.
  - Requesters must hold in_valid/in_data until accepted.
  - The arbiter may change its choice while stalled. The grant is not sticky before acceptance.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... and each requester is served exactly once per N beats.
- Single requester: a lone valid requester wins every cycle, including back-to-back cycles. ptr wraps to itself.
- Reset mid-operation: a pending beat is discarded (out_valid=0) and ptr returns to N-1. No in_ready is asserted during the reset cycle.
- in_valid dropped by a requester before acceptance is tolerated: arbitration simply re-evaluates next cycle.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - After requester i is accepted, search starts at i (not i+1) while the burst counter < MAX_BURST.
  - Counter increments per accepted beat from the same requester and resets to 1 when a different requester is accepted.
  - When the counter reaches MAX_BURST, the next search starts at i+1.
  - If i drops in_valid, the other requesters are served normally.
- Not defined:
  - Pointer advances past the winner after every beat; MAX_BURST is ignored.
  - Burst counter logic is absent.

Test Plan:
- Reset, then hold in_valid=4'b1111, in_data bytes 0x10,0x21,0x32,0x43, out_ready=1 -> from 1 cycle after first handshake, out_src sequence 0,1,2,3,0,1; out_data 0x10,0x21,0x32,0x43; one beat per cycle.
- Only requester 2 valid with data 0xA5, out_ready=1 for 5 cycles -> in_ready=4'b0100 every cycle; 5 beats of 0xA5 with out_src=2.
- Load one beat, then out_ready=0 for 3 cycles with all requesters valid -> out_valid=1 and out_data/out_src unchanged; in_ready=0; release gives next grant = previous winner + 1.
- in_valid=4'b1010, out_ready=1 -> alternating grants 1,3,1,3; assert rst for one cycle mid-stream -> out_valid=0 next cycle, first grant after reset = 1.
- ARB_BURST_EN, MAX_BURST=2, all requesters valid -> out_src sequence 0,0,1,1,2,2,3,3.
- ARB_BURST_EN, requester 0 valid for 1 beat only, others valid -> sequence 0,1,1,2,2,...; counter restarts on change.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbitrated N:1 mux feeding one registered valid/ready output channel.
// Optional feature macro: ARB_BURST_EN (lets a winner keep the grant for up to MAX_BURST beats).
`timescale 1ns/1ps

module mux_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    if (N < 2) begin : g_bad_n
        $error("mux_rr_arbiter: N must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("mux_rr_arbiter: MAX_BURST must be >= 1");
    end

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_succ;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] winner;
    logic          found;
    logic          can_load;
    logic          accept;
    logic [W-1:0]  sel_data;

    assign ptr_succ = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    assign can_load = !out_valid || out_ready;
    // Reset gates the handshake so no requester believes it was accepted in the reset cycle.
    assign accept   = found && can_load && !rst;

`ifdef ARB_BURST_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt;
    logic          burst_open;

    // A zero count means no burst is in progress yet, so the search starts past ptr.
    assign burst_open = (burst_cnt != '0) && (burst_cnt < CW'(MAX_BURST));
    assign start_idx  = burst_open ? ptr : ptr_succ;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (accept) begin
            if (burst_open && (winner == ptr)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= CW'(1);
            end
        end
    end
`else
    assign start_idx = ptr_succ;
`endif

    // Rotating priority search: first valid requester at or after start_idx, modulo N.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start_idx} + (IW + 1)'(k);
            idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == IW'(i)) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= LAST_IDX;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= winner;
            ptr       <= winner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
